vexriscv_axi_bridge: RTL
========================

Name: vexriscv_axi_bridge

Overview:
Parametrised bridge from one VexRiscv simple-bus port (iBus or dBus) to one AXI4 master port, with correct AXI handshakes. Supports multi-beat bursts, independent AW/W channels, write-response forwarding and error propagation. Performs address relocation into host memory and detects a "program done" store. One instance per CPU bus in the RISC-V kernel top.

Parameters:
ADDR_WIDTH, 64, AXI address width (>=32).
DATA_WIDTH, 32, AXI and CPU data width (32 or 64).
MAX_BEATS, 8, largest burst accepted, in beats (power of 2, <=256).
WRITE_RSP, 1, 1 = every completed write returns one rsp beat; 0 = writes are silent.
DONE_ADDR, 32'hFFFFFFF0, untranslated store address that signals completion.

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset; asynchronous, active-low
cfg_offset  in  ADDR_WIDTH  relocation base added to low addresses
cfg_abs_limit  in  32  addresses above this value pass through untranslated
cmd_valid / cmd_ready  in / out  1  CPU command handshake
cmd_wr  in  1  1 = write
cmd_address  in  32  byte address
cmd_data  in  DATA_WIDTH  write data beat
cmd_mask  in  DATA_WIDTH/8  byte enables
cmd_size  in  3  log2 of total transfer bytes
rsp_valid  out  1  response beat
rsp_last  out  1  final response beat
rsp_data  out  DATA_WIDTH  read data
rsp_error  out  1  AXI SLVERR/DECERR or oversize command
m_axi_aw{valid,ready,addr,len}  out,in,out,out  1,1,ADDR_WIDTH,8
m_axi_w{valid,ready,data,strb,last}  out,in,out,out,out  1,1,DATA_WIDTH,DATA_WIDTH/8,1
m_axi_b{valid,ready,resp}  in,out,in  1,1,2
m_axi_ar{valid,ready,addr,len}  out,in,out,out  1,1,ADDR_WIDTH,8
m_axi_r{valid,ready,data,last,resp}  in,out,in,in,in  1,1,DATA_WIDTH,1,2
done_pulse  out  1  one-cycle pulse on a DONE_ADDR store

Behaviour:
- Reset: state IDLE. All valid, ready and pulse outputs are 0. rsp_* and AXI payload outputs are 0.
- Beats: beats = max(1, 2^cmd_size / (DATA_WIDTH/8)); len = beats-1. The bridge generates wlast itself; cmd_last is ignored.
- Address: if cmd_address > cfg_abs_limit, use zero-extended cmd_address; else use cmd_address + cfg_offset, modulo 2^ADDR_WIDTH. Address and len are latched when the command is taken in IDLE.
- One transaction outstanding at a time. FSM states: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP, ERR_RSP, DONE.
- IDLE, read command: cmd_ready=1 for 1 cycle, then RD_ADDR.
- IDLE, write command: go to WR_DATA without consuming the beat (cmd_ready=0 in IDLE).
- IDLE, beats > MAX_BEATS: consume the command (a write consumes all its beats), no AXI traffic, then ERR_RSP.
- IDLE, write to exactly DONE_ADDR (untranslated) with beats=1: consume it, no AXI traffic, then DONE.
- RD_ADDR: arvalid held until arready, then RD_DATA.
- RD_DATA: rready=1. Each R beat is registered into rsp_*, so rsp_valid follows the beat with 1-cycle latency. rsp_error=rresp[1]; rsp_last=rlast. The rlast beat returns the FSM to IDLE.
- WR_DATA: awvalid is asserted from entry until awready, independent of W. wvalid=cmd_valid; cmd_ready=wready; wlast = (beat counter == len). After the last W handshake and AW are both done, go to WR_RESP; AW may complete before, with or after the last W beat.
- WR_RESP: bready=1. On bvalid, if WRITE_RSP=1, register rsp_valid=1, rsp_last=1, rsp_error=bresp[1]. Then IDLE.
- ERR_RSP: one rsp beat, rsp_valid=1, rsp_last=1, rsp_error=1. Then IDLE.
- DONE: done_pulse=1 for one cycle. If WRITE_RSP=1, also one rsp beat with error=0. Then IDLE.
- awvalid, arvalid and wvalid never deassert before their handshake, and payloads stay stable while valid.
- Asynchronous reset mid-burst aborts to IDLE immediately with all valids 0. Orphaned AXI beats are the host's responsibility.

Test Plan:
- Single read: cmd_address=0x100, cfg_abs_limit=0x1000, cfg_offset=0x8000_0000, size=2 -> araddr=0x8000_0100, arlen=0; R beat 0xDEADBEEF appears on rsp_data 1 cycle later with rsp_last=1.
- Burst read: size=5, DATA_WIDTH=32 -> arlen=7; 8 rsp beats, last only on the 8th. An rresp=2 on beat 3 gives rsp_error=1 on that beat only.
- Write, AW late: awready delayed 5 cycles after the single W beat -> exactly one AW handshake; bready only after both handshakes; bvalid gives one rsp beat with error=0.
- Burst write with wready toggling every cycle, size=4 -> awlen=3; wlast only on the 4th accepted beat; cmd_ready mirrors wready.
- Store to 0xFFFFFFF0 -> no AW/W activity, done_pulse high for exactly 1 cycle. cmd_address=0x1001 with limit 0x1000 -> address passes through untranslated.
- Oversize (size=7, MAX_BEATS=8) -> single rsp beat with rsp_error=1, no AXI traffic. Reset asserted mid-burst read -> all valids 0 the same cycle; the next command starts cleanly.

Source files
------------

// File: rtl/vexriscv_axi_bridge_if.sv
// Signal bundle between one VexRiscv simple-bus port and one AXI4 master port.
// master = bridge view (CPU-bus target, AXI initiator); slave = CPU + AXI host view.
interface vexriscv_axi_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_wr;
  logic [31:0]             cmd_address;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [DATA_WIDTH/8-1:0] cmd_mask;
  logic [2:0]              cmd_size;

  logic                    rsp_valid;
  logic                    rsp_last;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_error;

  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;

  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;

  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [1:0]              m_axi_bresp;

  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;

  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic                    m_axi_rlast;
  logic [1:0]              m_axi_rresp;

  modport master (
    input  cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask, cmd_size,
    output cmd_ready, rsp_valid, rsp_last, rsp_data, rsp_error,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask, cmd_size,
    input  cmd_ready, rsp_valid, rsp_last, rsp_data, rsp_error,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp,
    input  m_axi_rready
  );
endinterface

// File: rtl/vexriscv_axi_bridge.sv
// VexRiscv simple-bus to AXI4 master bridge: one transaction in flight, address
// relocation into host memory, burst support and "program done" store detection.
module vexriscv_axi_bridge #(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 32,
  parameter int          MAX_BEATS  = 8,
  parameter int          WRITE_RSP  = 1,
  parameter logic [31:0] DONE_ADDR  = 32'hFFFF_FFF0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_offset,
  input  logic [31:0]           cfg_abs_limit,
  vexriscv_axi_bridge_if.master bus,
  output logic                  done_pulse
);
  localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP, ERR_RSP, DONE
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, beat_q;
  logic                  aw_done, w_done, drop;
  logic [8:0]            beats;
  logic                  oversize, is_done, last_beat, wr_active;
  logic                  unused_ok;

  always_comb begin
    if (bus.cmd_size <= 3'(BYTE_SHIFT)) beats = 9'd1;
    else                                beats = 9'd1 << (bus.cmd_size - 3'(BYTE_SHIFT));
  end

  assign oversize  = beats > 9'(MAX_BEATS);
  assign is_done   = bus.cmd_wr && (bus.cmd_address == DONE_ADDR) && (beats == 9'd1);
  assign addr_d    = (bus.cmd_address > cfg_abs_limit) ? ADDR_WIDTH'(bus.cmd_address)
                                                       : cfg_offset + ADDR_WIDTH'(bus.cmd_address);
  assign last_beat = beat_q == len_q;
  assign wr_active = (state == WR_DATA) && !drop && !w_done;

  assign bus.m_axi_awaddr = addr_q;
  assign bus.m_axi_awlen  = len_q;
  assign bus.m_axi_araddr = addr_q;
  assign bus.m_axi_arlen  = len_q;
  assign bus.m_axi_wdata  = wr_active ? bus.cmd_data : '0;
  assign bus.m_axi_wstrb  = wr_active ? bus.cmd_mask : '0;
  assign bus.m_axi_wlast  = wr_active && last_beat;
  assign unused_ok        = ^{bus.m_axi_rresp[0], bus.m_axi_bresp[0]};

  always_comb begin
    state_d           = state;
    bus.cmd_ready     = 1'b0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_rready  = 1'b0;
    bus.m_axi_bready  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && ap_rst_n) begin
          if (oversize) begin
            if (bus.cmd_wr) state_d = WR_DATA;
            else begin
              bus.cmd_ready = 1'b1;
              state_d       = ERR_RSP;
            end
          end else if (is_done) begin
            bus.cmd_ready = 1'b1;
            state_d       = DONE;
          end else if (bus.cmd_wr) begin
            state_d = WR_DATA;
          end else begin
            bus.cmd_ready = 1'b1;
            state_d       = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        bus.m_axi_arvalid = 1'b1;
        if (bus.m_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid && bus.m_axi_rlast) state_d = RD_ADDR == RD_ADDR ? IDLE : IDLE;
      end
      WR_DATA: begin
        // Oversize writes reuse WR_DATA with AXI suppressed, just to swallow the beats.
        if (drop) begin
          bus.cmd_ready = 1'b1;
          if (bus.cmd_valid && last_beat) state_d = ERR_RSP;
        end else begin
          bus.m_axi_awvalid = !aw_done;
          bus.m_axi_wvalid  = bus.cmd_valid && !w_done;
          bus.cmd_ready     = bus.m_axi_wready && !w_done;
          if ((aw_done || bus.m_axi_awready) &&
              (w_done || (bus.cmd_valid && bus.m_axi_wready && last_beat)))
            state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) state_d = IDLE;
      end
      ERR_RSP: state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      drop          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_error <= 1'b0;
      done_pulse    <= 1'b0;
    end else begin
      state         <= state_d;
      done_pulse    <= state_d == DONE;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (state_d != IDLE) begin
            addr_q  <= addr_d;
            len_q   <= 8'(beats - 9'd1);
            beat_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            drop    <= oversize;
          end
        end
        RD_DATA: begin
          if (bus.m_axi_rvalid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_last  <= bus.m_axi_rlast;
            bus.rsp_data  <= bus.m_axi_rdata;
            bus.rsp_error <= bus.m_axi_rresp[1];
          end
        end
        WR_DATA: begin
          if (bus.m_axi_awvalid && bus.m_axi_awready) aw_done <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) w_done <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bus.m_axi_bvalid && (WRITE_RSP != 0)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_last  <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_error <= bus.m_axi_bresp[1];
          end
        end
        default: ;
      endcase
      // Synthetic responses are loaded on entry so they coincide with ERR_RSP/DONE.
      if (state_d == ERR_RSP) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_last  <= 1'b1;
        bus.rsp_data  <= '0;
        bus.rsp_error <= 1'b1;
      end
      if (state_d == DONE && WRITE_RSP != 0) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_last  <= 1'b1;
        bus.rsp_data  <= '0;
        bus.rsp_error <= 1'b0;
      end
    end
  end
endmodule
